// File: rtl/l1_cache_ctrl.sv
// 4-way set-associative write-back/write-allocate L1 data cache controller with 16-word line bursts.
// Optional hit/miss counters are built only when CACHE_STATS_EN is defined; otherwise stat_* are tied to 0.
module l1_cache_ctrl #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int INDEX_W    = 6,
    parameter int LINE_WORDS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses
);
    localparam int NUM_WAYS = 4;
    localparam int NUM_SETS = 1 << INDEX_W;
    localparam int WSEL_W   = $clog2(LINE_WORDS);
    localparam int OFF_W    = WSEL_W + 2;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFF_W;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_RESPOND, S_WRITEBACK, S_REFILL} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:2]   req_addr_q, req_addr_d;
    logic                req_we_q, req_we_d;
    logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [WSEL_W-1:0]   word_cnt_q, word_cnt_d;
    logic [1:0]          victim_q, victim_d;

    logic [NUM_WAYS-1:0][NUM_SETS-1:0] valid_q, dirty_q;
    logic [NUM_SETS-1:0][2:0]          plru_q;
    logic [TAG_W-1:0]  tag_mem  [NUM_WAYS][NUM_SETS];
    logic [DATA_W-1:0] data_mem [NUM_WAYS][NUM_SETS][LINE_WORDS];

    wire unused_addr_bits = ^cpu_addr[1:0];

    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] req_idx;
    logic [WSEL_W-1:0]  req_word;
    assign req_tag  = req_addr_q[ADDR_W-1 -: TAG_W];
    assign req_idx  = req_addr_q[OFF_W +: INDEX_W];
    assign req_word = req_addr_q[2 +: WSEL_W];

    // Tree PLRU: bit0 picks the half, bit1/bit2 pick within it; touching a way points the tree away from it.
    function automatic logic [2:0] plru_touch(input logic [2:0] p, input logic [1:0] way);
        logic [2:0] n;
        n    = p;
        n[0] = ~way[1];
        if (!way[1]) n[1] = ~way[0];
        else         n[2] = ~way[0];
        return n;
    endfunction

    logic       hit;
    logic [1:0] hit_way;
    always_comb begin
        hit     = 1'b0;
        hit_way = 2'd0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[w][req_idx] && tag_mem[w][req_idx] == req_tag) begin
                hit     = 1'b1;
                hit_way = 2'(w);
            end
        end
    end

    logic [1:0] victim_sel;
    logic [2:0] plru_cur;
    always_comb begin
        plru_cur = plru_q[req_idx];
        if      (!valid_q[0][req_idx]) victim_sel = 2'd0;
        else if (!valid_q[1][req_idx]) victim_sel = 2'd1;
        else if (!valid_q[2][req_idx]) victim_sel = 2'd2;
        else if (!valid_q[3][req_idx]) victim_sel = 2'd3;
        else if (plru_cur[0])          victim_sel = plru_cur[2] ? 2'd3 : 2'd2;
        else                           victim_sel = plru_cur[1] ? 2'd1 : 2'd0;
    end

    logic              hit_upd, wb_done, rf_done, tag_wr_en, data_wr_en;
    logic [1:0]        data_wr_way;
    logic [WSEL_W-1:0] data_wr_word;
    logic [DATA_W-1:0] data_wr_val;

    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        req_we_d     = req_we_q;
        req_wdata_d  = req_wdata_q;
        rdata_d      = rdata_q;
        word_cnt_d   = word_cnt_q;
        victim_d     = victim_q;
        hit_upd      = 1'b0;
        wb_done      = 1'b0;
        rf_done      = 1'b0;
        tag_wr_en    = 1'b0;
        data_wr_en   = 1'b0;
        data_wr_way  = victim_q;
        data_wr_word = word_cnt_q;
        data_wr_val  = mem_rdata;
        unique case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    req_addr_d  = cpu_addr[ADDR_W-1:2];
                    req_we_d    = cpu_we;
                    req_wdata_d = cpu_wdata;
                    state_d     = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit) begin
                    hit_upd      = 1'b1;
                    data_wr_en   = req_we_q;
                    data_wr_way  = hit_way;
                    data_wr_word = req_word;
                    data_wr_val  = req_wdata_q;
                    if (!req_we_q) rdata_d = data_mem[hit_way][req_idx][req_word];
                    state_d      = S_RESPOND;
                end else begin
                    victim_d   = victim_sel;
                    word_cnt_d = '0;
                    state_d    = (valid_q[victim_sel][req_idx] && dirty_q[victim_sel][req_idx])
                                 ? S_WRITEBACK : S_REFILL;
                end
            end
            S_WRITEBACK: begin
                if (mem_ack) begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (word_cnt_q == WSEL_W'(LINE_WORDS - 1)) begin
                        wb_done = 1'b1;
                        state_d = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                if (mem_ack) begin
                    data_wr_en = 1'b1;
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (word_cnt_q == WSEL_W'(LINE_WORDS - 1)) begin
                        rf_done   = 1'b1;
                        tag_wr_en = 1'b1;
                        state_d   = S_LOOKUP;
                    end
                end
            end
            S_RESPOND: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            req_addr_q  <= '0;
            req_we_q    <= 1'b0;
            req_wdata_q <= '0;
            rdata_q     <= '0;
            word_cnt_q  <= '0;
            victim_q    <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
            plru_q      <= '0;
        end else begin
            state_q     <= state_d;
            req_addr_q  <= req_addr_d;
            req_we_q    <= req_we_d;
            req_wdata_q <= req_wdata_d;
            rdata_q     <= rdata_d;
            word_cnt_q  <= word_cnt_d;
            victim_q    <= victim_d;
            if (hit_upd) begin
                plru_q[req_idx] <= plru_touch(plru_q[req_idx], hit_way);
                if (req_we_q) dirty_q[hit_way][req_idx] <= 1'b1;
            end
            if (wb_done) dirty_q[victim_q][req_idx] <= 1'b0;
            if (rf_done) begin
                valid_q[victim_q][req_idx] <= 1'b1;
                dirty_q[victim_q][req_idx] <= 1'b0;
            end
        end
    end

    // Storage arrays carry no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (data_wr_en) data_mem[data_wr_way][req_idx][data_wr_word] <= data_wr_val;
        if (tag_wr_en)  tag_mem[victim_q][req_idx] <= req_tag;
    end

    assign cpu_ack   = (state_q == S_RESPOND);
    assign cpu_rdata = rdata_q;
    assign mem_req   = (state_q == S_WRITEBACK) || (state_q == S_REFILL);
    assign mem_we    = (state_q == S_WRITEBACK);
    assign mem_wdata = mem_we ? data_mem[victim_q][req_idx][word_cnt_q] : '0;

    always_comb begin
        mem_addr = '0;
        if (state_q == S_WRITEBACK)
            mem_addr = {tag_mem[victim_q][req_idx], req_idx, word_cnt_q, 2'b00};
        else if (state_q == S_REFILL)
            mem_addr = {req_tag, req_idx, word_cnt_q, 2'b00};
    end

`ifdef CACHE_STATS_EN
    logic        first_q, first_d;
    logic [31:0] hits_q, hits_d, misses_q, misses_d;

    // Only the first lookup of a request counts; the post-refill lookup is not a new hit.
    always_comb begin
        first_d  = first_q;
        hits_d   = hits_q;
        misses_d = misses_q;
        if (state_q == S_IDLE && cpu_req) first_d = 1'b1;
        if (state_q == S_LOOKUP) begin
            first_d = 1'b0;
            if (first_q && hit && hits_q != 32'hFFFF_FFFF)     hits_d   = hits_q + 32'd1;
            if (first_q && !hit && misses_q != 32'hFFFF_FFFF)  misses_d = misses_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q  <= 1'b0;
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            first_q  <= first_d;
            hits_q   <= hits_d;
            misses_q <= misses_d;
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`else
    assign stat_hits   = '0;
    assign stat_misses = '0;
`endif

endmodule

// File: tb/tb_l1_cache_ctrl.sv
// Bench for l1_cache_ctrl: table-driven hit/miss vectors, eviction/stall/reset sequences and a random phase
// checked against a flat word-addressed memory model and a responder that serves the burst port.
module tb_l1_cache_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] stat_hits, stat_misses;

    l1_cache_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stat_hits(stat_hits), .stat_misses(stat_misses)
    );

    initial forever #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Backing memory: words never written return an address-derived pattern.
    logic [31:0] mem_model [logic [31:0]];
    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return a ^ 32'hA5A5_5A5A;
    endfunction

    int          ack_period = 1;
    int          stall_cnt = 0;
    int          rf_acks = 0, wb_acks = 0, we_seen = 0, addr_err = 0;
    logic [31:0] wb_first = '0, wb_last = '0;
    logic        prev_req = 1'b0, prev_we = 1'b0, prev_ack = 1'b0;
    logic [31:0] prev_addr = '0;

    task automatic clr_mon();
        rf_acks = 0; wb_acks = 0; we_seen = 0; wb_first = '0; wb_last = '0;
    endtask

    // Memory responder: acks every ack_period-th cycle of an active burst.
    initial forever begin
        @(negedge clk);
        mem_ack = 1'b0;
        if (mem_req) begin
            if (prev_req && prev_we == mem_we &&
                mem_addr != (prev_ack ? prev_addr + 32'd4 : prev_addr))
                addr_err++;
            if (mem_we) we_seen++;
            stall_cnt++;
            if (stall_cnt % ack_period == 0) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    mem_model[mem_addr] = mem_wdata;
                    wb_acks++;
                    if (wb_acks == 1) wb_first = mem_addr;
                    wb_last = mem_addr;
                end else begin
                    rf_acks++;
                    mem_rdata = mem_read(mem_addr);
                end
            end
        end else begin
            stall_cnt = 0;
        end
        prev_req  = mem_req;
        prev_we   = mem_we;
        prev_ack  = mem_ack;
        prev_addr = mem_addr;
    end

    // Called at a negedge; returns at a negedge one cycle after the ack.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!cpu_ack && lat < 2000);
        if (!cpu_ack) chk("ack_timeout", {31'd0, cpu_ack}, 32'd1);
        rd = cpu_rdata;
        cpu_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;
    vec_t vecs[32];

    logic [31:0] rd;
    int          lat;
    logic [31:0] ev_data[5];
    logic [31:0] rnd_addr[64];
    logic [31:0] rnd_data[64];
    logic [31:0] ref_mem [logic [31:0]];

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_stat_hits", stat_hits, 32'd0);
        chk("rst_stat_misses", stat_misses, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Simple RW table: first write is a refill (19 cycles with ack every cycle), the rest hit in 2.
        for (int i = 0; i < 16; i++) begin
            vecs[i]      = '{1'b1, 32'(i * 4), 32'h0F0F_0000 + 32'(i), 1'b0, 32'd0, (i == 0) ? 19 : 2};
            vecs[16 + i] = '{1'b0, 32'(i * 4), 32'd0, 1'b1, 32'h0F0F_0000 + 32'(i), 2};
        end
        clr_mon();
        for (int i = 0; i < 32; i++) begin
            access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat);
            chk($sformatf("rw_lat[%0d]", i), 32'(lat), 32'(vecs[i].exp_lat));
            if (vecs[i].chk_rd) chk($sformatf("rw_rdata[%0d]", i), rd, vecs[i].exp_rd);
        end
        chk("rw_refill_acks", 32'(rf_acks), 32'd16);
        chk("rw_wb_acks", 32'(wb_acks), 32'd0);
`ifdef CACHE_STATS_EN
        chk("rw_stat_misses", stat_misses, 32'd1);
        chk("rw_stat_hits", stat_hits, 32'd31);
`else
        chk("rw_stat_misses", stat_misses, 32'd0);
        chk("rw_stat_hits", stat_hits, 32'd0);
`endif

        // Eviction: five tags into set 0; tag 5 evicts dirty tag 1.
        do_reset();
        ev_data = '{32'h00FEDC00, 32'h000CAAB0, 32'h0DAAA000, 32'h0FFFFF00, 32'hEEEEEE0D};
        for (int t = 1; t <= 4; t++) begin
            clr_mon();
            access(1'b1, 32'(t << 12) | 32'h10, ev_data[t - 1], rd, lat);
            chk($sformatf("ev_fill_wb[%0d]", t), 32'(wb_acks), 32'd0);
        end
        clr_mon();
        access(1'b1, 32'h0000_5010, ev_data[4], rd, lat);
        chk("ev_wb_acks", 32'(wb_acks), 32'd16);
        chk("ev_wb_first", wb_first, 32'h0000_1000);
        chk("ev_wb_last", wb_last, 32'h0000_103C);
        chk("ev_wb_word4", mem_read(32'h0000_1010), 32'h00FE_DC00);
        chk("ev_rf_acks", 32'(rf_acks), 32'd16);
        clr_mon();
        access(1'b0, 32'h0000_1010, 32'd0, rd, lat);
        chk("ev_rd_wb_acks", 32'(wb_acks), 32'd16);
        chk("ev_rd_victim_tag3", wb_first, 32'h0000_3000);
        chk("ev_rd_rf_acks", 32'(rf_acks), 32'd16);
        chk("ev_rd_data", rd, 32'h00FE_DC00);

        // Clean miss
        clr_mon();
        access(1'b0, 32'h00AB_C048, 32'd0, rd, lat);
        chk("clean_rf_acks", 32'(rf_acks), 32'd16);
        chk("clean_we_seen", 32'(we_seen), 32'd0);
        chk("clean_rdata", rd, 32'h00AB_C048 ^ 32'hA5A5_5A5A);

        // Stalled memory
        clr_mon();
        addr_err = 0;
        ack_period = 3;
        access(1'b0, 32'h00DD_D0B4, 32'd0, rd, lat);
        ack_period = 1;
        chk("stall_rf_acks", 32'(rf_acks), 32'd16);
        chk("stall_addr_err", 32'(addr_err), 32'd0);
        chk("stall_rdata", rd, 32'h00DD_D0B4 ^ 32'hA5A5_5A5A);

        // Reset after 7 refill acks
        clr_mon();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0077_7104;
        for (int c = 0; c < 200 && rf_acks < 7; c++) begin
            @(posedge clk);
            #2;
        end
        chk("rstmid_acks_seen", 32'(rf_acks), 32'd7);
        rst_n = 1'b0;
        cpu_req = 1'b0;
        #1;
        chk("rstmid_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rstmid_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clr_mon();
        access(1'b0, 32'h0077_7104, 32'd0, rd, lat);
        chk("rstmid_rf_acks", 32'(rf_acks), 32'd16);
        chk("rstmid_rdata", rd, 32'h0077_7104 ^ 32'hA5A5_5A5A);

        // Random writes then reads in the same order.
        addr_err = 0;
        for (int i = 0; i < 64; i++) begin
            rnd_addr[i] = {20'h00040 + 20'($urandom_range(0, 5)), 6'($urandom_range(0, 1)),
                           4'($urandom_range(0, 15)), 2'b00};
            rnd_data[i] = $urandom;
            ref_mem[rnd_addr[i]] = rnd_data[i];
            ack_period = $urandom_range(1, 2);
            access(1'b1, rnd_addr[i], rnd_data[i], rd, lat);
        end
        for (int i = 0; i < 64; i++) begin
            ack_period = $urandom_range(1, 2);
            access(1'b0, rnd_addr[i], 32'd0, rd, lat);
            chk($sformatf("rnd_rd[%0d]@%h", i, rnd_addr[i]), rd, ref_mem[rnd_addr[i]]);
        end
        chk("rnd_addr_err", 32'(addr_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/l1_cache_ctrl.md
Name: l1_cache_ctrl

Overview:
- 4-way set-associative, write-back, write-allocate data cache controller.
- Sits directly downstream of the CPU request port and consumes its word read/write requests.
- Issues 16-word line bursts to the memory model on misses and dirty evictions.
- Address split: tag[31:12], index[11:6] (64 sets), offset[5:0] (64-byte line, word select = offset[5:2]).

Parameters:
- ADDR_W, 32, address width; fixed split as above.
- DATA_W, 32, word width.
- INDEX_W, 6, set index bits (64 sets).
- LINE_WORDS, 16, words per line (burst length).

Ports:
- clk  in  1  single clock, all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  request valid; held until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req.
- cpu_addr  in  32  byte address; offset[1:0] ignored.
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  read data; valid in the cpu_ack cycle.
- cpu_ack  out  1  one-cycle completion pulse.
- mem_req  out  1  memory burst active.
- mem_we  out  1  1 = writeback burst, 0 = refill burst.
- mem_addr  out  32  current word address in the burst.
- mem_wdata  out  32  writeback word.
- mem_rdata  in  32  refill word, valid with mem_ack.
- mem_ack  in  1  one word transferred this cycle.
- stat_hits  out  32  hit counter (optional feature).
- stat_misses  out  32  miss counter (optional feature).

Behaviour:
- Reset (async, rst_n=0):
  - All valid, dirty and PLRU bits cleared; state IDLE.
  - cpu_ack=0, cpu_rdata=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, stat_*=0.
  - Data/tag arrays not reset.
- FSM: IDLE -> LOOKUP -> {RESPOND | WRITEBACK | REFILL}; WRITEBACK -> REFILL -> LOOKUP.
- IDLE: on cpu_req=1, latch addr, we and wdata; go to LOOKUP. cpu_req while busy is not re-sampled until after cpu_ack.
- LOOKUP:
  - Compare tag against the 4 ways of the set.
  - Hit: read returns the word; write updates the word and sets dirty. Update PLRU. Go to RESPOND.
  - Hit latency: cpu_ack two cycles after the cycle cpu_req is first sampled in IDLE.
- Miss victim selection:
  - Lowest-numbered invalid way first; otherwise the 3-bit tree PLRU victim.
  - Victim dirty -> WRITEBACK, else -> REFILL.
- WRITEBACK:
  - mem_req=1, mem_we=1.
  - mem_addr = {victim_tag, index, word_cnt, 2'b00}, starting at word 0.
  - word_cnt advances on each mem_ack; after 16 acks, clear dirty and go to REFILL.
- REFILL:
  - mem_req=1, mem_we=0, mem_addr = {req_tag, index, word_cnt, 2'b00}.
  - Each mem_ack writes mem_rdata into the victim way.
  - After 16 acks: set valid, clear dirty, write the tag, return to LOOKUP. The lookup then hits.
- mem_req deasserts the cycle after the 16th ack.
- mem_req stays high through the WRITEBACK->REFILL transition; mem_we flips and word_cnt restarts at 0.
- RESPOND: cpu_ack=1 for exactly one cycle; cpu_rdata holds until the next ack; return to IDLE.
- PLRU bits are updated on every hit, including the post-refill lookup. The accessed way becomes MRU.
- Boundaries:
  - word_cnt wraps 15 -> 0 only at burst end.
  - mem_ack outside mem_req is ignored.
  - Reset mid-burst aborts immediately: mem_req drops asynchronously and the line is left invalid.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined:
  - stat_hits increments once per request that hits on its first LOOKUP.
  - stat_misses increments once per request that misses on its first LOOKUP.
  - Both are 32-bit, saturate at FFFFFFFF, and reset to 0.
- Not defined: counter logic is absent and both ports are tied to 0.

Test Plan:
- Simple RW:
  - Write 0x0F0F0000+i to addresses 0..60 step 4.
  - First write -> one 16-ack refill; all later accesses hit with 2-cycle latency; reads return 0x0F0F0000+i.
  - With the macro: stat_misses=1, stat_hits=31.
- Eviction:
  - Write tags 1..5 at index 0, offset 0x10, data 0x00FEDC00, 0x000CAAB0, 0x0DAAA000, 0x0FFFFF00, 0xEEEEEE0D.
  - Write of tag 5 evicts tag 1: dirty writeback burst at 0x00001000-0x0000103C, mem_wdata 0x00FEDC00 at 0x00001010.
  - Read of tag 1 then writes back the PLRU victim, refills, and returns 0x00FEDC00.
- Clean miss:
  - Read an untouched address.
  - Response: REFILL only, mem_we=0 throughout, no writeback burst.
- Stalled memory:
  - mem_ack pulses every 3rd cycle during refill.
  - Response: exactly 16 words captured, mem_addr increments by 4 only after each ack, correct data returned.
- Reset mid-refill:
  - rst_n low after 7 acks.
  - Response: mem_req=0 immediately; a re-read of the same address misses and refills fully.
- Random:
  - 64 random-address/data writes, then reads in the same order.
  - Response: every read matches the last data written to that word address.
